// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between the execute result (A) and the load result (B).
// Optional macro RF_ARB_FWD_EN adds a combinational bypass of the write landing this cycle.
module regfile_write_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_WAIT      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef RF_ARB_FWD_EN
  input  logic [ADDRESS_WIDTH-1:0] AD1_i,
  input  logic [ADDRESS_WIDTH-1:0] AD2_i,
  output logic                     fwd1_o,
  output logic                     fwd2_o,
  output logic [DATA_WIDTH-1:0]    fwd_data_o,
`endif
  input  logic                     a_valid_i,
  output logic                     a_ready_o,
  input  logic [ADDRESS_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0]    a_data_i,
  input  logic                     b_valid_i,
  output logic                     b_ready_o,
  input  logic [ADDRESS_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0]    b_data_i,
  output logic                     WE3_o,
  output logic [ADDRESS_WIDTH-1:0] AD3_o,
  output logic [DATA_WIDTH-1:0]    WD3_o,
  output logic                     starve_o
);

  // A MAX_WAIT of 0 would give a zero-width counter; keep one bit that simply stays at 0.
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]         wait_cnt;
  logic                     b_at_limit;
  logic                     grant_a;
  logic                     grant_b;
  logic                     vld_p0;
  logic [ADDRESS_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0]    data_p0;
  logic                     we_p1;
  logic [ADDRESS_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0]    data_p1;

  // Stage p0: combinational grant and winner selection
  assign b_at_limit = (wait_cnt == WAIT_LIMIT);

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    addr_p0 = a_addr_i;
    data_p0 = a_data_i;
    if (!rst) begin
      if (b_valid_i && (!a_valid_i || b_at_limit)) begin
        grant_b = 1'b1;
        addr_p0 = b_addr_i;
        data_p0 = b_data_i;
      end else if (a_valid_i) begin
        grant_a = 1'b1;
      end
    end
  end

  assign vld_p0    = grant_a || grant_b;
  assign a_ready_o = grant_a;
  assign b_ready_o = grant_b;
  assign starve_o  = b_at_limit && b_valid_i;

  // B's consecutive-loss counter; only a pending, ungranted B write makes it grow
  always_ff @(posedge clk) begin
    if (rst || !b_valid_i || grant_b) begin
      wait_cnt <= '0;
    end else if (!b_at_limit) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Stage p1: registered write toward the register file; x0 writes never raise the enable
  always_ff @(posedge clk) begin
    if (rst) begin
      we_p1   <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else if (vld_p0) begin
      we_p1   <= (addr_p0 != '0);
      addr_p1 <= addr_p0;
      data_p1 <= data_p0;
    end else begin
      we_p1   <= 1'b0;
    end
  end

  assign WE3_o = we_p1;
  assign AD3_o = addr_p1;
  assign WD3_o = data_p1;

`ifdef RF_ARB_FWD_EN
  assign fwd1_o     = we_p1 && (addr_p1 == AD1_i);
  assign fwd2_o     = we_p1 && (addr_p1 == AD2_i);
  assign fwd_data_o = data_p1;
`endif

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port (WE3/AD3/WD3) between two writeback sources: the execute-stage result (requester A) and the load/memory result (requester B). Fixed priority A, with a starvation limit that forces a grant to B. Registers the winning write so the register file sees a clean, one-cycle-delayed write. Sits between the writeback muxing and the register file.

Parameters:
ADDRESS_WIDTH, 5, register address width
DATA_WIDTH, 32, register data width
MAX_WAIT, 3, consecutive lost cycles B tolerates before forced grant (0 = B always wins a collision)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
a_valid_i  input  1  requester A has a write
a_ready_o  output  1  A write accepted this cycle
a_addr_i  input  ADDRESS_WIDTH  A destination register
a_data_i  input  DATA_WIDTH  A write data
b_valid_i  input  1  requester B has a write
b_ready_o  output  1  B write accepted this cycle
b_addr_i  input  ADDRESS_WIDTH  B destination register
b_data_i  input  DATA_WIDTH  B write data
WE3_o  output  1  register-file write enable
AD3_o  output  ADDRESS_WIDTH  register-file write address
WD3_o  output  DATA_WIDTH  register-file write data
starve_o  output  1  high when wait_cnt == MAX_WAIT and b_valid_i

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset: WE3_o=0, AD3_o=0, WD3_o=0, wait_cnt=0; a_ready_o=b_ready_o=0 while rst=1.
- Grant (combinational, same cycle):
  - only A valid -> grant A
  - only B valid -> grant B
  - both valid -> grant B if wait_cnt == MAX_WAIT, else grant A
  - x_ready_o = grant to x; at most one ready high per cycle.
- Transfer = valid && ready. Requesters hold valid, addr and data stable until transfer.
- wait_cnt (width $clog2(MAX_WAIT+1)):
  - cleared when B transfers or b_valid_i=0
  - incremented when b_valid_i=1 and B not granted
  - saturates at MAX_WAIT
- Output register, one-cycle latency:
  - On a transfer, next cycle: AD3_o/WD3_o = winner addr/data, WE3_o = (addr != 0).
  - Writes to x0 are accepted (ready high) but never assert WE3_o.
  - With no transfer, WE3_o=0 next cycle; AD3_o/WD3_o hold previous values.
- Throughput: one write per cycle; back-to-back transfers give WE3_o high on consecutive cycles.
- Reset during a transfer cycle: the transfer is discarded and WE3_o=0 on the following cycle.

Optional Feature:
Macro RF_ARB_FWD_EN.
- Defined: adds inputs AD1_i and AD2_i (ADDRESS_WIDTH) and outputs fwd1_o, fwd2_o (1) and fwd_data_o (DATA_WIDTH). Forwarding is combinational:
  - fwd1_o = WE3_o && (AD3_o == AD1_i); fwd2_o likewise for AD2_i
  - fwd_data_o = WD3_o
  - Lets the read path bypass the write landing this cycle.
- Undefined: these ports and this logic do not exist; behaviour is otherwise identical.

Test Plan:
1. rst=1 for 2 cycles with a_valid_i=b_valid_i=1 -> both ready=0, WE3_o=0, AD3_o=0, WD3_o=0; after release, A is granted in the first cycle.
2. A only, addr 5, data 0xDEADBEEF -> a_ready_o=1 same cycle; next cycle WE3_o=1, AD3_o=5, WD3_o=0xDEADBEEF; following cycle WE3_o=0.
3. MAX_WAIT=3, both valid continuously (A addr 1, B addr 2 data 0x55):
   - A granted cycles 0-2; starve_o=1 in cycle 3; B granted cycle 3.
   - WE3_o/AD3_o=2/WD3_o=0x55 in cycle 4; A granted cycle 4.
4. B only, addr 0, data 0x1234 -> b_ready_o=1, WE3_o stays 0; wait_cnt=0 afterwards.
5. A transfer (addr 7) in the same cycle as rst=1 -> WE3_o=0 next cycle; register 7 is never written.
6. With RF_ARB_FWD_EN, WE3_o=1, AD3_o=9, AD1_i=9, AD2_i=3 -> fwd1_o=1, fwd2_o=0, fwd_data_o=WD3_o; with AD3_o=0 (x0 accepted), fwd1_o=0.
